// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: producer side of the register-file write port.
// Collects ALU results and raw load words, formats loads by funct3/offset,
// queues loads in a small FIFO, and drives one registered write per cycle.
// Also maintains the pending-destination bitmap used by decode for stalls.
//
// Handshake rule for both input channels (alu_*, ld_*): a transfer happens
// on a rising edge where valid and ready are both high. Ready never depends
// on valid, so the producer may wait for ready before raising valid or hold
// valid high; once a transfer happens the offered item is consumed.
module rf_writeback_ctrl #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int LQ_DEPTH  = 4,
    localparam int RW       = $clog2(NREG),
    localparam int PW       = $clog2(LQ_DEPTH),
    localparam int CW       = $clog2(LQ_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [RW-1:0]   iss_rd,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [RW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    output logic            wr_en,
    output logic [RW-1:0]   wr_reg,
    output logic [XLEN-1:0] wr_data,
    output logic [NREG-1:0] pending,
    output logic [CW-1:0]   lq_count
);

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Load queue storage; pointers wrap naturally because depth is a power of 2
    logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
    logic [RW-1:0]   lq_rd_q   [LQ_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    // Registered write port and scoreboard
    logic            wr_en_q,   wr_en_d;
    logic [RW-1:0]   wr_reg_q,  wr_reg_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0] pending_q, pending_d;

    // Handshake and selection signals
    logic            ld_fire;
    logic            alu_fire;
    logic            lq_pop;
    logic            sel_valid;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            wr_fire;

    // Load formatting intermediates
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;

    // Readiness uses only the start-of-cycle occupancy, so a pop in the
    // same cycle never opens a slot early and the ALU never bypasses loads.
    assign ld_ready  = reset && (count_q != CW'(LQ_DEPTH));
    assign alu_ready = reset && (count_q == '0);
    assign ld_fire   = ld_valid  && ld_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign lq_pop    = (count_q != '0);

    // Extract the addressed byte and halfword from the aligned memory word
    always_comb begin
        ld_byte = ld_data[7:0];
        case (ld_offset)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_data[31:16] : ld_data[15:0];
    end

    // Sign/zero extend according to the load type; unknown types pass the word
    always_comb begin
        ld_fmt = ld_data;
        case (ld_funct3)
            F3_LB:   ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = ld_data;
        endcase
    end

    // Pick the write source: queued load first, otherwise an accepted ALU result
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (lq_pop) begin
            sel_valid = 1'b1;
            sel_rd    = lq_rd_q[rd_ptr_q];
            sel_data  = lq_data_q[rd_ptr_q];
        end else if (alu_fire) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end
    end

    // x0 results are consumed but never reach the register file
    assign wr_fire = sel_valid && (sel_rd != '0);

    // Next-state for queue pointers, write port and pending bitmap
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wr_en_d   = wr_fire;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        pending_d = pending_q;

        if (lq_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (ld_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(ld_fire) - CW'(lq_pop);

        if (wr_fire) begin
            wr_reg_d  = sel_rd;
            wr_data_d = sel_data;
            pending_d[sel_rd] = 1'b0;
        end
        // A new producer issued on the same edge as the old one retires keeps the bit set
        if (iss_valid) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    // Queue payload storage; contents are don't-care while the queue is empty
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            lq_data_q[wr_ptr_q] <= ld_fmt;
            lq_rd_q[wr_ptr_q]   <= ld_rd;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign pending  = pending_q;
    assign lq_count = count_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: random and directed stimulus against a
// queue-level reference model; writes are checked by an independent monitor.
module tb_rf_writeback_ctrl;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int LQ_DEPTH = 4;
    localparam int RW       = 5;
    localparam int EW       = RW + XLEN;

    // Clock and DUT signals
    logic            clk = 1'b0;
    logic            reset;
    logic            iss_valid;
    logic [RW-1:0]   iss_rd;
    logic            alu_valid;
    logic            alu_ready;
    logic [RW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [RW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_offset;
    logic            wr_en;
    logic [RW-1:0]   wr_reg;
    logic [XLEN-1:0] wr_data;
    logic [NREG-1:0] pending;
    logic [2:0]      lq_count;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_funct3 (ld_funct3),
        .ld_offset (ld_offset),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .pending   (pending),
        .lq_count  (lq_count)
    );

    // Scoreboard state
    int              checks   = 0;
    int              failures = 0;
    logic [EW-1:0]   exp_q[$];
    bit              mon_en = 1'b0;

    // Reference model: current state (after last edge) and next state
    logic [EW-1:0]   m_lq[$];
    logic [EW-1:0]   n_lq[$];
    logic [NREG-1:0] m_pend = '0, n_pend;
    logic [RW-1:0]   m_reg  = '0, n_reg;
    logic [XLEN-1:0] m_data = '0, n_data;
    logic            n_en;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endfunction

    // Load result from the architectural rules: pick byte/half, then extend
    function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (8 * int'(off))) & 32'h0000_00FF;
        h = (raw >> (16 * int'(off[1]))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    // Driver: evaluate the model for the current inputs, advance one edge, commit
    task automatic cycle();
        logic          have;
        logic [EW-1:0] w;
        n_lq   = m_lq;
        n_pend = m_pend;
        n_reg  = m_reg;
        n_data = m_data;
        n_en   = 1'b0;
        if (!reset) begin
            n_lq.delete();
            n_pend = '0;
            n_reg  = '0;
            n_data = '0;
        end else begin
            have = 1'b0;
            w    = '0;
            if (m_lq.size() != 0) begin
                w    = n_lq.pop_front();
                have = 1'b1;
            end else if (alu_valid) begin
                w    = {alu_rd, alu_data};
                have = 1'b1;
            end
            if (have && (w[EW-1:XLEN] != '0)) begin
                n_en   = 1'b1;
                n_reg  = w[EW-1:XLEN];
                n_data = w[XLEN-1:0];
                n_pend[n_reg] = 1'b0;
            end
            if (ld_valid && (m_lq.size() < LQ_DEPTH))
                n_lq.push_back({ld_rd, fmt_load(ld_data, ld_funct3, ld_offset)});
            if (iss_valid && (iss_rd != '0))
                n_pend[iss_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        m_lq   = n_lq;
        m_pend = n_pend;
        m_reg  = n_reg;
        m_data = n_data;
        if (n_en) exp_q.push_back({n_reg, n_data});
        mon_en = 1'b1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    // Monitor: compare DUT outputs with the model away from the active edge
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (mon_en) begin
            check("wr_en", 64'(wr_en), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (wr_en) check("wr_target", 64'({wr_reg, wr_data}), 64'(e));
            end
            check("wr_hold", 64'({wr_reg, wr_data}), 64'({m_reg, m_data}));
            check("pending", 64'(pending), 64'(m_pend));
            check("lq_count", 64'(lq_count), 64'(m_lq.size()));
            check("ld_ready", 64'(ld_ready), 64'(reset && (m_lq.size() < LQ_DEPTH)));
            check("alu_ready", 64'(alu_ready), 64'(reset && (m_lq.size() == 0)));
        end
    end

    task automatic directed_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] want, input string name);
        ld_valid  = 1'b1;
        ld_rd     = 5'd7;
        ld_data   = 32'h80FF7F01;
        ld_funct3 = f3;
        ld_offset = off;
        cycle();
        ld_valid = 1'b0;
        cycle();
        @(negedge clk);
        check({name, "_en"}, 64'(wr_en), 64'd1);
        check(name, 64'(wr_data), 64'(want));
    endtask

    initial begin
        // Reset held low two cycles with traffic offered
        reset = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1111;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h2222; ld_funct3 = 3'b010; ld_offset = 2'd0;
        cycle();
        cycle();
        @(negedge clk);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_lq_count", 64'(lq_count), 64'd0);
        reset = 1'b1;
        idle_inputs();
        cycle();

        // ALU write with a previously issued destination
        iss_valid = 1'b1; iss_rd = 5'd5;
        cycle();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        @(negedge clk);
        check("pend5_set", 64'(pending[5]), 64'd1);
        cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        check("alu_wr_en", 64'(wr_en), 64'd1);
        check("alu_wr_reg", 64'(wr_reg), 64'd5);
        check("alu_wr_data", 64'(wr_data), 64'h1234);
        check("pend5_clr", 64'(pending[5]), 64'd0);

        // Load formatting
        directed_load(3'b000, 2'd3, 32'hFFFFFF80, "lb_off3");
        directed_load(3'b100, 2'd1, 32'h0000007F, "lbu_off1");
        directed_load(3'b001, 2'd2, 32'hFFFF80FF, "lh_off2");
        directed_load(3'b010, 2'd0, 32'h80FF7F01, "lw");

        // Four back-to-back loads with the ALU held valid behind them
        ld_valid = 1'b1; ld_funct3 = 3'b010; ld_offset = 2'd0;
        ld_rd = 5'd10; ld_data = 32'hA000_0010;
        cycle();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_00A1;
        for (int i = 1; i < 4; i++) begin
            ld_rd   = 5'(10 + i);
            ld_data = 32'hA000_0010 + 32'(i);
            @(negedge clk);
            check("stream_alu_ready", 64'(alu_ready), 64'd0);
            check("stream_lq_count", 64'(lq_count), 64'd1);
            cycle();
        end
        ld_valid = 1'b0;
        @(negedge clk);
        check("last_load_alu_ready", 64'(alu_ready), 64'd0);
        cycle();
        @(negedge clk);
        check("drained_alu_ready", 64'(alu_ready), 64'd1);
        cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        check("alu_after_loads_reg", 64'(wr_reg), 64'd20);
        cycle();

        // ALU result to x0 is consumed silently
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        @(negedge clk);
        check("rd0_alu_ready", 64'(alu_ready), 64'd1);
        cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        check("rd0_wr_en", 64'(wr_en), 64'd0);
        check("rd0_pend0", 64'(pending[0]), 64'd0);

        // Issue and retire of r9 on the same edge keeps it pending
        iss_valid = 1'b1; iss_rd = 5'd9;
        cycle();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        cycle();
        idle_inputs();
        @(negedge clk);
        check("r9_wr_en", 64'(wr_en), 64'd1);
        check("r9_wr_reg", 64'(wr_reg), 64'd9);
        check("r9_pending", 64'(pending[9]), 64'd1);

        // Reset while a load sits in the queue
        ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b010; ld_data = 32'hCAFE_F00D;
        cycle();
        reset = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        check("mid_lq_count", 64'(lq_count), 64'd1);
        cycle();
        @(negedge clk);
        check("mid_rst_lq_count", 64'(lq_count), 64'd0);
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        reset = 1'b1;
        cycle();
        cycle();
        @(negedge clk);
        check("post_rst_no_write", 64'(wr_en), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) != 0);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = 5'($urandom_range(0, 31));
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data  = $urandom();
            ld_valid  = ($urandom_range(0, 2) != 0);
            ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld_data   = $urandom();
            ld_funct3 = 3'($urandom_range(0, 7));
            ld_offset = 2'($urandom_range(0, 3));
            cycle();
        end

        // Drain and finish
        reset = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        cycle();
        @(negedge clk);
        #1;
        check("drain_exp_q", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
